half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent half-adder lanes.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the carry-event counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port a_in, input, WIDTH bits: addend A, one bit per lane.
REQ-007 The block SHALL have port b_in, input, WIDTH bits: addend B, one bit per lane.
REQ-008 The block SHALL have port sum_out, output, WIDTH bits: combinational per-lane sum.
REQ-009 The block SHALL have port carry_out, output, WIDTH bits: combinational per-lane carry.
REQ-010 The block SHALL have port sum_q, output, WIDTH bits: registered copy of sum_out.
REQ-011 The block SHALL have port carry_q, output, WIDTH bits: registered copy of carry_out.
REQ-012 The block SHALL have port out_valid, output, 1 bit: high when sum_q and carry_q hold a captured result.
REQ-013 The block SHALL have port carry_cnt, output, CNT_W bits: carry-event counter.

Function
REQ-014 Per lane i, sum_out[i] SHALL equal a_in[i] XOR b_in[i], combinationally with zero latency and independent of clk and rst_n.
REQ-015 Per lane i, carry_out[i] SHALL equal a_in[i] AND b_in[i], combinationally with zero latency and independent of clk and rst_n.
REQ-016 For WIDTH=1, {carry_out, sum_out} SHALL be: 00 for a,b=00; 01 for 01; 01 for 10; 10 for 11.
REQ-017 Lanes SHALL be independent; no carry SHALL propagate between lanes.
REQ-018 On every rising clk edge with rst_n high, sum_q and carry_q SHALL capture sum_out and carry_out (latency 1 cycle).
REQ-019 out_valid SHALL go high on the first rising edge after reset release and stay high until the next reset.
REQ-020 There SHALL be no handshake; inputs SHALL be sampled every cycle.

Reset
REQ-021 Asserting rst_n low SHALL immediately force sum_q=0, carry_q=0, out_valid=0 and carry_cnt=0, without waiting for a clock edge.
REQ-022 Reset SHALL NOT affect sum_out or carry_out.
REQ-023 A reset asserted mid-operation SHALL discard the registered state.
REQ-024 The first capture after reset release SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-025 With macro HALF_ADDER_CARRY_CNT_EN defined, carry_cnt SHALL increment by 1 on each rising edge where carry_out has any bit set.
REQ-026 With HALF_ADDER_CARRY_CNT_EN defined, carry_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 Without HALF_ADDER_CARRY_CNT_EN, carry_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-028 Package half_adder_pkg SHALL hold the default WIDTH and CNT_W constants and the saturating-count maximum helper.
REQ-029 A sub-module half_adder_cell (1-bit, combinational: a, b -> sum, carry) SHALL be instantiated once per lane through a generate loop.
REQ-030 Registers and the counter SHALL reside in the top module.

Verification
REQ-031 WIDTH=1, no clock, {a_in,b_in} stepped 0..3 every 10 time units -> sum_out,carry_out = 0,0; 1,0; 1,0; 0,1, each settled within the step.
REQ-032 WIDTH=4, a_in=4'b1100, b_in=4'b1010 -> sum_out=4'b0110, carry_out=4'b1000; one edge later sum_q=4'b0110, carry_q=4'b1000.
REQ-033 rst_n low mid-run with non-zero sum_q -> sum_q, carry_q, out_valid and carry_cnt read 0 before the next clk edge; sum_out still tracks inputs.
REQ-034 Macro defined, CNT_W=2, a_in=b_in=1 held for 5 edges -> carry_cnt reads 1,2,3,3,3.
REQ-035 Macro undefined, a_in=b_in=1 held for 10 edges -> carry_cnt stays 0.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the multi-lane half adder.
// Defaults for lane count and carry-counter width, plus the saturation limit helper.
package half_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // All-ones value of a w-bit counter; a shift by 64 yields 0, so w=64 still gives all ones.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder: sum = a ^ b, carry = a & b.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with registered copies and an optional carry-event counter.
// The counter is built only when HALF_ADDER_CARRY_CNT_EN is defined; otherwise carry_cnt is 0.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0] carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic             valid_d;
    logic             valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a_in[i]),
            .b     (b_in[i]),
            .sum   (sum_out[i]),
            .carry (carry_out[i])
        );
    end

    // No handshake: inputs are captured on every edge; out_valid only marks
    // that at least one capture has happened since reset was released.
    always_comb begin
        sum_d   = sum_out;
        carry_d = carry_out;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;

    // Count edges with any lane carrying, holding at the maximum instead of wrapping.
    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if ((|carry_out) && (carry_cnt_q != CNT_MAX)) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt_q <= '0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: one 1-lane instance for the truth table and one 4-lane,
// 2-bit-counter instance for registered, reset and counter behaviour.
module tb_half_adder;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic [0:0]    a1, b1;
    logic [0:0]    s1, c1, sq1, cq1;
    logic          v1;
    logic [15:0]   cnt1;
    logic [W-1:0]  a4, b4;
    logic [W-1:0]  sum_out, carry_out, sum_q, carry_q;
    logic          out_valid;
    logic [CW-1:0] carry_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: values expected to be captured on the next edge, and
    // the number of carry edges seen since the last reset.
    logic [2*W-1:0] exp_q[$];
    int             carry_events;

    half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a1),
        .b_in      (b1),
        .sum_out   (s1),
        .carry_out (c1),
        .sum_q     (sq1),
        .carry_q   (cq1),
        .out_valid (v1),
        .carry_cnt (cnt1)
    );

    half_adder #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a4),
        .b_in      (b4),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .out_valid (out_valid),
        .carry_cnt (carry_cnt)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: per-lane arithmetic sum a+b, result returned as {carry, sum}.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s, c;
        for (int i = 0; i < W; i++) begin
            int t;
            t    = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    function automatic int exp_cnt();
`ifdef HALF_ADDER_CARRY_CNT_EN
        int lim;
        lim = (1 << CW) - 1;
        return (carry_events > lim) ? lim : carry_events;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive new inputs away from the edge and check the combinational outputs.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] e;
        @(negedge clk);
        a4 = a;
        b4 = b;
        #1;
        e = model(a, b);
        check("sum_out", 32'(sum_out), 32'(e[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(e[2*W-1:W]));
        exp_q.delete();
        exp_q.push_back(e);
    endtask

    // One rising edge, then check the registered outputs against the model.
    task automatic clock();
        logic [2*W-1:0] e;
        @(posedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : model(a4, b4);
        exp_q.push_back(e);
        if (e[2*W-1:W] != '0) carry_events++;
        #1;
        check("sum_q", 32'(sum_q), 32'(e[W-1:0]));
        check("carry_q", 32'(carry_q), 32'(e[2*W-1:W]));
        check("out_valid", 32'(out_valid), 32'd1);
        check("carry_cnt", 32'(carry_cnt), 32'(exp_cnt()));
    endtask

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } tt_t;

    initial begin
        tt_t tt[4];
        int  seq[5];

        tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        rst_n        = 1'b0;
        a1           = '0;
        b1           = '0;
        a4           = '0;
        b4           = '0;
        carry_events = 0;

        // Reset state
        #1;
        check("rst_sum_q", 32'(sum_q), 32'd0);
        check("rst_carry_q", 32'(carry_q), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_carry_cnt", 32'(carry_cnt), 32'd0);

        // Truth table on the 1-lane instance, combinational, reset held
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a;
            b1 = tt[i].b;
            #5;
            check("tt_sum", 32'(s1), 32'(tt[i].s));
            check("tt_carry", 32'(c1), 32'(tt[i].c));
            #5;
        end

        // Release reset between edges: nothing captured until the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge_valid", 32'(out_valid), 32'd0);
        check("pre_edge_sum_q", 32'(sum_q), 32'd0);

        // Four-lane vector, lanes independent
        drive(4'b1100, 4'b1010);
        check("vec_sum_out", 32'(sum_out), 32'h6);
        check("vec_carry_out", 32'(carry_out), 32'h8);
        clock();
        check("vec_sum_q", 32'(sum_q), 32'h6);
        check("vec_carry_q", 32'(carry_q), 32'h8);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            drive(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            clock();
        end

        // Asynchronous reset mid-run with non-zero registered sum
        drive(4'b1111, 4'b0110);
        clock();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum_q", 32'(sum_q), 32'd0);
        check("mid_rst_carry_q", 32'(carry_q), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnt", 32'(carry_cnt), 32'd0);
        a4 = 4'b0101;
        b4 = 4'b0011;
        #1;
        check("rst_sum_out", 32'(sum_out), 32'h6);
        check("rst_carry_out", 32'(carry_out), 32'h1);
        carry_events = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_sum_q", 32'(sum_q), 32'd0);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry counter: all lanes carry-free first, then one carrying lane held
        drive(4'b0000, 4'b0000);
        clock();
        check("cnt_idle", 32'(carry_cnt), 32'd0);
        seq = '{1, 2, 3, 3, 3};
        drive(4'b0001, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            clock();
`ifdef HALF_ADDER_CARRY_CNT_EN
            if (k < 5) check("cnt_seq", 32'(carry_cnt), 32'(seq[k]));
`else
            check("cnt_off", 32'(carry_cnt), 32'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
